// File: rtl/pipelined_inverter_pkg.sv
// Default parameter constants shared by the pipelined inverter and its stage.
package pipelined_inverter_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/inv_pipe_stage.sv
// One valid/ready register stage: loads from upstream whenever it is empty
// or the downstream side is taking its current word.
module inv_pipe_stage
    import pipelined_inverter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             up_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign up_ready = !r_valid || dn_ready;

    // NOTE: non-blocking assignments keep every stage sampling its upstream's
    // pre-edge value, so a chain of stages shifts instead of collapsing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (up_ready) begin
            r_valid <= up_valid;
            r_data  <= up_data;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule

// File: rtl/pipelined_inverter.sv
// Masked bitwise inversion at entry, followed by a STAGES-deep valid/ready
// pipeline with full backpressure and a wrapping output-transfer counter.
module pipelined_inverter
    import pipelined_inverter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_count
);

    logic [STAGES:0]   w_rdy;
    logic [STAGES-1:0] w_valid;
    logic [WIDTH-1:0]  w_data [STAGES];
    logic [WIDTH-1:0]  w_in_word;
    logic [CNT_W-1:0]  r_xfer_count;

    assign w_in_word     = in_data ^ mask;
    assign w_rdy[STAGES] = out_ready;

    // Ready ripples combinationally from the consumer back to the producer.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (g == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = w_in_word;
        end else begin : g_body
            assign w_up_valid = w_valid[g-1];
            assign w_up_data  = w_data[g-1];
        end

        inv_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .up_valid(w_up_valid),
            .up_data (w_up_data),
            .dn_ready(w_rdy[g+1]),
            .up_ready(w_rdy[g]),
            .valid   (w_valid[g]),
            .data    (w_data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            r_xfer_count <= r_xfer_count + CNT_W'(1);
        end
    end

    assign in_ready   = w_rdy[0];
    assign out_valid  = w_valid[STAGES-1];
    assign out_data   = w_data[STAGES-1];
    assign xfer_count = r_xfer_count;

endmodule
